// File: rtl/repetition_pkg.sv
// ----------------------------------------------------------------------------
// repetition_pkg
//   Shared definitions for the repetition-code transmitter:
//     - state_t       : transmitter FSM states (IDLE, SEND)
//     - rep_w()       : width of the repetition index for a given NUM_REPEAT
//     - bit_w()       : width of the bit index for a given DATA_W
//     - repeat_legal(): NUM_REPEAT must be odd and >= 3 so a majority exists
//     - data_w_legal(): DATA_W must be at least one bit
// ----------------------------------------------------------------------------
package repetition_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index widths never drop below one bit, so a single-entry range
    // still gets a real (always-zero) register.
    function automatic int rep_w(input int num_repeat);
        return (num_repeat <= 1) ? 1 : $clog2(num_repeat);
    endfunction

    function automatic int bit_w(input int data_w);
        return (data_w <= 1) ? 1 : $clog2(data_w);
    endfunction

    // An even count or fewer than three copies leaves the receiver's
    // majority vote without a strict winner.
    function automatic bit repeat_legal(input int num_repeat);
        return (num_repeat >= 3) && ((num_repeat % 2) == 1);
    endfunction

    function automatic bit data_w_legal(input int data_w);
        return (data_w >= 1);
    endfunction

endpackage

// File: rtl/repetition_beat_counter.sv
// ----------------------------------------------------------------------------
// repetition_beat_counter
//   Nested position counter for the serial beat stream. rep_idx counts the
//   repetitions of one data bit; when it wraps, bit_idx moves to the next
//   data bit, and a bit_idx wrap ends the word.
//
//   The counter reports the position of the *next* beat so that the parent
//   can register tx_* outputs in the same edge that the counter moves.
//
//   Ports
//     clk          in   rising-edge clock
//     rst_n        in   synchronous reset, active-low
//     i_load       in   start a new word: next position is (bit 0, rep 0)
//     i_advance    in   current beat handshaked: move one position on
//     o_rep_idx    out  repetition index of the next beat
//     o_bit_idx    out  data-bit index of the next beat
//     o_grp_first  out  next beat is repetition 0 of its data bit
//     o_grp_last   out  next beat is the final repetition of its data bit
//     o_word_last  out  next beat is the final beat of the word
// ----------------------------------------------------------------------------
module repetition_beat_counter
    import repetition_pkg::*;
#(
    parameter  int NUM_REPEAT = 5,
    parameter  int DATA_W     = 8,
    localparam int REP_W      = rep_w(NUM_REPEAT),
    localparam int BIT_W      = bit_w(DATA_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_advance,
    output logic [REP_W-1:0] o_rep_idx,
    output logic [BIT_W-1:0] o_bit_idx,
    output logic             o_grp_first,
    output logic             o_grp_last,
    output logic             o_word_last
);

    // Terminal counts are explicit so non-power-of-two ranges wrap correctly.
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(NUM_REPEAT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    logic [REP_W-1:0] r_rep_idx;
    logic [BIT_W-1:0] r_bit_idx;
    logic [REP_W-1:0] w_next_rep;
    logic [BIT_W-1:0] w_next_bit;
    logic             w_cur_grp_last;
    logic             w_cur_bit_last;

    assign w_cur_grp_last = (r_rep_idx == REP_MAX);
    assign w_cur_bit_last = (r_bit_idx == BIT_MAX);

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_rep = r_rep_idx;
        w_next_bit = r_bit_idx;
        if (i_load) begin
            w_next_rep = '0;
            w_next_bit = '0;
        end else if (i_advance) begin
            if (w_cur_grp_last) begin
                w_next_rep = '0;
                w_next_bit = w_cur_bit_last ? '0 : (r_bit_idx + BIT_W'(1));
            end else begin
                w_next_rep = r_rep_idx + REP_W'(1);
            end
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rep_idx <= '0;
            r_bit_idx <= '0;
        end else begin
            r_rep_idx <= w_next_rep;
            r_bit_idx <= w_next_bit;
        end
    end

    assign o_rep_idx   = w_next_rep;
    assign o_bit_idx   = w_next_bit;
    assign o_grp_first = (w_next_rep == '0);
    assign o_grp_last  = (w_next_rep == REP_MAX);
    assign o_word_last = (w_next_rep == REP_MAX) && (w_next_bit == BIT_MAX);

endmodule

// File: rtl/repetition_code_tx.sv
// ----------------------------------------------------------------------------
// repetition_code_tx
//   Transmit side of a repetition-code link. Accepts DATA_W-bit words on a
//   valid/ready handshake and sends each bit LSB-first, NUM_REPEAT times in a
//   row, on a serial beat stream with downstream backpressure. A per-word
//   injection mask inverts chosen repetitions of every bit so the receiver's
//   majority vote can be exercised.
//
//   Ports
//     clk           in   rising-edge clock
//     rst_n         in   synchronous reset, active-low
//     in_valid      in   upstream word valid
//     in_ready      out  word accepted when in_valid && in_ready
//     in_data       in   word to send, LSB first
//     in_inj_mask   in   bit r set inverts repetition r of every bit
//     tx_valid      out  serial beat valid
//     tx_ready      in   downstream takes the beat when tx_valid && tx_ready
//     tx_bit        out  beat value: data[bit_idx] ^ mask[rep_idx]
//     tx_grp_first  out  beat is repetition 0 of a data bit
//     tx_grp_last   out  beat is the last repetition of a data bit
//     tx_word_last  out  beat is the last beat of the word
// ----------------------------------------------------------------------------
module repetition_code_tx
    import repetition_pkg::*;
#(
    parameter int NUM_REPEAT = 5,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [NUM_REPEAT-1:0] in_inj_mask,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_bit,
    output logic                  tx_grp_first,
    output logic                  tx_grp_last,
    output logic                  tx_word_last
);

    localparam int REP_W = rep_w(NUM_REPEAT);
    localparam int BIT_W = bit_w(DATA_W);

    generate
        if (!repeat_legal(NUM_REPEAT)) begin : g_bad_num_repeat
            $error("repetition_code_tx: NUM_REPEAT must be odd and >= 3");
        end
        if (!data_w_legal(DATA_W)) begin : g_bad_data_w
            $error("repetition_code_tx: DATA_W must be >= 1");
        end
    endgenerate

    state_t                r_state;
    logic [DATA_W-1:0]     r_data;
    logic [NUM_REPEAT-1:0] r_mask;
    logic                  r_tx_valid;
    logic                  r_tx_bit;
    logic                  r_tx_grp_first;
    logic                  r_tx_grp_last;
    logic                  r_tx_word_last;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_beat_fire;
    logic                  w_last_fire;
    logic [DATA_W-1:0]     w_src_data;
    logic [NUM_REPEAT-1:0] w_src_mask;
    logic [REP_W-1:0]      w_next_rep;
    logic [BIT_W-1:0]      w_next_bit;
    logic                  w_next_grp_first;
    logic                  w_next_grp_last;
    logic                  w_next_word_last;
    logic                  w_next_bit_val;

    // A new word is taken when idle, or on the very cycle the final beat of
    // the current word handshakes, which removes any bubble between words.
    // Holding in_ready low while rst_n is low keeps reset from accepting.
    assign w_in_ready  = rst_n && ((r_state == IDLE) || (r_tx_word_last && tx_ready));
    assign w_accept    = in_valid && w_in_ready;
    assign w_beat_fire = r_tx_valid && tx_ready;
    assign w_last_fire = w_beat_fire && r_tx_word_last;

    repetition_beat_counter #(
        .NUM_REPEAT (NUM_REPEAT),
        .DATA_W     (DATA_W)
    ) u_beat_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_accept),
        .i_advance   (w_beat_fire),
        .o_rep_idx   (w_next_rep),
        .o_bit_idx   (w_next_bit),
        .o_grp_first (w_next_grp_first),
        .o_grp_last  (w_next_grp_last),
        .o_word_last (w_next_word_last)
    );

    // On an accept the first beat is built straight from the incoming word,
    // since the data/mask registers only update at the same edge.
    assign w_src_data     = w_accept ? in_data     : r_data;
    assign w_src_mask     = w_accept ? in_inj_mask : r_mask;
    assign w_next_bit_val = w_src_data[w_next_bit] ^ w_src_mask[w_next_rep];

    // FSM, word registers and registered beat outputs. Outputs only change
    // on an accept or a beat handshake, so they hold steady under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_data         <= '0;
            r_mask         <= '0;
            r_tx_valid     <= 1'b0;
            r_tx_bit       <= 1'b0;
            r_tx_grp_first <= 1'b0;
            r_tx_grp_last  <= 1'b0;
            r_tx_word_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state        <= SEND;
                        r_data         <= in_data;
                        r_mask         <= in_inj_mask;
                        r_tx_valid     <= 1'b1;
                        r_tx_bit       <= w_next_bit_val;
                        r_tx_grp_first <= w_next_grp_first;
                        r_tx_grp_last  <= w_next_grp_last;
                        r_tx_word_last <= w_next_word_last;
                    end
                end
                SEND: begin
                    if (w_last_fire && !w_accept) begin
                        r_state        <= IDLE;
                        r_tx_valid     <= 1'b0;
                        r_tx_bit       <= 1'b0;
                        r_tx_grp_first <= 1'b0;
                        r_tx_grp_last  <= 1'b0;
                        r_tx_word_last <= 1'b0;
                    end else if (w_beat_fire) begin
                        // Covers both a mid-word step and a back-to-back
                        // reload on the final beat (w_accept is only
                        // possible on that final beat while in SEND).
                        if (w_accept) begin
                            r_data <= in_data;
                            r_mask <= in_inj_mask;
                        end
                        r_tx_valid     <= 1'b1;
                        r_tx_bit       <= w_next_bit_val;
                        r_tx_grp_first <= w_next_grp_first;
                        r_tx_grp_last  <= w_next_grp_last;
                        r_tx_word_last <= w_next_word_last;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign tx_valid     = r_tx_valid;
    assign tx_bit       = r_tx_bit;
    assign tx_grp_first = r_tx_grp_first;
    assign tx_grp_last  = r_tx_grp_last;
    assign tx_word_last = r_tx_word_last;

endmodule

// File: tb/tb_repetition_code_tx.sv
// ----------------------------------------------------------------------------
// tb_repetition_code_tx
//   Directed bench for repetition_code_tx with NUM_REPEAT=5, DATA_W=8.
//   Inputs change 1 ns after a rising edge; outputs are sampled 2 ns after.
// ----------------------------------------------------------------------------
module tb_repetition_code_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] in_inj_mask;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_bit;
    logic       tx_grp_first;
    logic       tx_grp_last;
    logic       tx_word_last;

    int n_checks = 0;
    int n_errors = 0;

    repetition_code_tx #(
        .NUM_REPEAT (5),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_inj_mask  (in_inj_mask),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_bit       (tx_bit),
        .tx_grp_first (tx_grp_first),
        .tx_grp_last  (tx_grp_last),
        .tx_word_last (tx_word_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Presents a word at posedge+1, confirms in_ready, lets it be accepted,
    // and returns at posedge+1 of the first cycle after the accept edge.
    task automatic send_word(input logic [7:0] d, input logic [4:0] m,
                             input bit hold, input logic [7:0] d_next,
                             input string tag);
        in_valid    = 1'b1;
        in_data     = d;
        in_inj_mask = m;
        tx_ready    = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s accept_ready: in_ready=%b required 1", tag, in_ready);
        end
        @(posedge clk);
        #1;
        if (hold) in_data = d_next;
        else      in_valid = 1'b0;
    endtask

    // Walks nbeats beats. Each cycle compares {valid,bit,first,last,wlast}
    // against the beat position; beats 0..39 belong to d0, 40..79 to d1.
    // Also rebuilds the bit stream and majority-decodes each group.
    task automatic run_beats(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [4:0] m, input int nbeats,
                             input bit stall, input string tag,
                             output logic [79:0] seq, output logic [15:0] dec);
        int b;
        int cyc;
        int ones;
        int w;
        int lb;
        int bi;
        int ri;
        logic [7:0] dw;
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        b    = 0;
        cyc  = 0;
        ones = 0;
        seq  = '0;
        dec  = '0;
        while ((b < nbeats) && (cyc < 400)) begin
            tx_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            #1;
            w  = b / 40;
            lb = b % 40;
            bi = lb / 5;
            ri = lb % 5;
            dw = (w == 0) ? d0 : d1;
            exp_v = {1'b1, dw[bi] ^ m[ri], (ri == 0), (ri == 4), (ri == 4) && (bi == 7)};
            obs_v = {tx_valid, tx_bit, tx_grp_first, tx_grp_last, tx_word_last};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s beat %0d cyc %0d {valid,bit,first,last,wlast}: got %b required %b",
                         tag, b, cyc, obs_v, exp_v);
            end
            if (b == 10) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s busy_ready: in_ready=%b required 0", tag, in_ready);
                end
            end
            if ((nbeats == 80) && (b == 39) && tx_ready) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s last_beat_ready: in_ready=%b required 1", tag, in_ready);
                end
            end
            if (tx_ready) begin
                seq[b] = tx_bit;
                ones += int'(tx_bit);
                if (ri == 4) begin
                    dec[w*8 + bi] = (ones >= 3);
                    ones = 0;
                end
                b++;
            end
            cyc++;
            @(posedge clk);
            #1;
            if (b >= 40) in_valid = 1'b0;
        end
        if (b < nbeats) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: got %0d beats required %0d", tag, b, nbeats);
        end
    endtask

    task automatic check_idle(input string tag);
        #1;
        n_checks++;
        if ({tx_valid, in_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL %s idle: {tx_valid,in_ready}=%b required 01", tag, {tx_valid, in_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'hA5;
        in_inj_mask = 5'b0;
        tx_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({tx_valid, tx_bit, tx_grp_first, tx_grp_last, tx_word_last, in_ready} !== 6'b0) begin
                n_errors++;
                $display("FAIL reset cyc %0d outputs: got %b required 000000", i,
                         {tx_valid, tx_bit, tx_grp_first, tx_grp_last, tx_word_last, in_ready});
            end
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_clean_word();
        logic [79:0] seq;
        logic [15:0] dec;
        send_word(8'hA5, 5'b0, 1'b0, 8'h00, "clean");
        run_beats(8'hA5, 8'h00, 5'b0, 40, 1'b0, "clean", seq, dec);
        n_checks++;
        if (seq[39:0] !== 40'hF8_3E00_7C1F) begin
            n_errors++;
            $display("FAIL clean stream: got %h required f83e007c1f", seq[39:0]);
        end
        check_idle("clean");
    endtask

    task automatic test_stall();
        logic [79:0] seq;
        logic [15:0] dec;
        send_word(8'hA5, 5'b0, 1'b0, 8'h00, "stall");
        run_beats(8'hA5, 8'h00, 5'b0, 40, 1'b1, "stall", seq, dec);
        n_checks++;
        if (seq[39:0] !== 40'hF8_3E00_7C1F) begin
            n_errors++;
            $display("FAIL stall stream: got %h required f83e007c1f", seq[39:0]);
        end
        tx_ready = 1'b1;
        check_idle("stall");
    endtask

    task automatic test_back_to_back();
        logic [79:0] seq;
        logic [15:0] dec;
        send_word(8'h01, 5'b0, 1'b1, 8'hFF, "b2b");
        run_beats(8'h01, 8'hFF, 5'b0, 80, 1'b0, "b2b", seq, dec);
        n_checks++;
        if (seq !== {40'hFF_FFFF_FFFF, 40'h00_0000_001F}) begin
            n_errors++;
            $display("FAIL b2b stream: got %h required ffffffffff000000001f", seq);
        end
        n_checks++;
        if (dec !== 16'hFF01) begin
            n_errors++;
            $display("FAIL b2b decoded: got %h required ff01", dec);
        end
        check_idle("b2b");
    endtask

    task automatic test_inject();
        logic [79:0] seq;
        logic [15:0] dec;
        send_word(8'h3C, 5'b00011, 1'b0, 8'h00, "inj2");
        run_beats(8'h3C, 8'h00, 5'b00011, 40, 1'b0, "inj2", seq, dec);
        n_checks++;
        if (dec[7:0] !== 8'h3C) begin
            n_errors++;
            $display("FAIL inj2 decoded: got %h required 3c", dec[7:0]);
        end
        check_idle("inj2");
        send_word(8'h3C, 5'b00111, 1'b0, 8'h00, "inj3");
        run_beats(8'h3C, 8'h00, 5'b00111, 40, 1'b0, "inj3", seq, dec);
        n_checks++;
        if (dec[7:0] !== 8'hC3) begin
            n_errors++;
            $display("FAIL inj3 decoded: got %h required c3", dec[7:0]);
        end
        check_idle("inj3");
    endtask

    task automatic test_reset_mid_word();
        logic [79:0] seq;
        logic [15:0] dec;
        send_word(8'hA5, 5'b0, 1'b0, 8'h00, "midrst");
        run_beats(8'hA5, 8'h00, 5'b0, 16, 1'b0, "midrst", seq, dec);
        #1;
        n_checks++;
        if (tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst beat17_valid: tx_valid=%b required 1", tx_valid);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({tx_valid, tx_bit, tx_grp_first, tx_grp_last, tx_word_last, in_ready} !== 6'b0) begin
            n_errors++;
            $display("FAIL midrst reset outputs: got %b required 000000",
                     {tx_valid, tx_bit, tx_grp_first, tx_grp_last, tx_word_last, in_ready});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({tx_valid, in_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL midrst after_release: {tx_valid,in_ready}=%b required 01", {tx_valid, in_ready});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst no_leftover: tx_valid=%b required 0", tx_valid);
        end
        send_word(8'h5A, 5'b0, 1'b0, 8'h00, "post_rst");
        run_beats(8'h5A, 8'h00, 5'b0, 40, 1'b0, "post_rst", seq, dec);
        n_checks++;
        if (seq[39:0] !== 40'h07_C1FF_83E0) begin
            n_errors++;
            $display("FAIL post_rst stream: got %h required 07c1ff83e0", seq[39:0]);
        end
        check_idle("post_rst");
    endtask

    initial begin
        test_reset();
        test_clean_word();
        test_stall();
        test_back_to_back();
        test_inject();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
